// File: rtl/risc_int_pkg.sv
// Shared types and default parameters for the RISC interrupt controller.
package risc_int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } int_state_t;

    localparam int          NSRC_DEF       = 4;
    localparam int          AW_DEF         = 32;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0040;
    localparam int          VEC_STRIDE_DEF = 8;

    // A single-source build still needs a one-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(NSRC_DEF);

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending requests.
module int_prio_enc
    import risc_int_pkg::*;
#(
    parameter  int N  = NSRC_DEF,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/risc_int_ctrl.sv
// Interrupt controller: edge latching, enable mask, priority pick and req/ack/iret handshake.
// Define INT_SYNC_EN to put a 2-flop synchronizer on every int_src bit.
module risc_int_ctrl
    import risc_int_pkg::*;
#(
    parameter  int            NSRC       = NSRC_DEF,
    parameter  int            AW         = AW_DEF,
    parameter  logic [AW-1:0] VEC_BASE   = AW'(VEC_BASE_DEF),
    parameter  int            VEC_STRIDE = VEC_STRIDE_DEF,
    localparam int            IDW        = id_width(NSRC)
) (
    input  logic            boardclk,
    input  logic            rst,
    input  logic [NSRC-1:0] int_src,
    input  logic            en_we,
    input  logic [NSRC-1:0] en_wdata,
    output logic [NSRC-1:0] en,
    output logic [NSRC-1:0] pending,
    output logic            irq_req,
    input  logic            irq_ack,
    output logic [IDW-1:0]  irq_id,
    output logic [AW-1:0]   irq_vec,
    input  logic            iret,
    output logic            in_service
);

    int_state_t      state_q;
    int_state_t      state_d;
    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending_d;
    logic            win_valid;
    logic [IDW-1:0]  win_idx;
    logic            capture;
    logic            take;

`ifdef INT_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    always_ff @(posedge boardclk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= int_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = int_src;
`endif

    assign rise = src_s & ~prev_q;

    int_prio_enc #(
        .N (NSRC)
    ) u_prio (
        .req   (pending & en),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_ff @(posedge boardclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_req    = 1'b0;
        in_service = 1'b0;
        capture    = 1'b0;
        take       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    capture = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                irq_req = 1'b1;
                if (irq_ack) begin
                    take    = 1'b1;
                    state_d = SERV;
                end
            end
            SERV: begin
                in_service = 1'b1;
                if (iret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The new-edge OR comes after the ack clear so a same-cycle edge keeps the bit set.
    always_comb begin
        pending_d = pending;
        if (take) begin
            pending_d[irq_id] = 1'b0;
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge boardclk) begin
        if (rst) begin
            prev_q  <= '0;
            pending <= '0;
            en      <= '0;
            irq_id  <= '0;
            irq_vec <= '0;
        end else begin
            prev_q  <= src_s;
            pending <= pending_d;
            if (en_we) begin
                en <= en_wdata;
            end
            if (capture) begin
                irq_id  <= win_idx;
                irq_vec <= VEC_BASE + AW'(VEC_STRIDE) * AW'(win_idx);
            end
        end
    end

endmodule

// File: tb/tb_risc_int_ctrl.sv
// Self-checking bench for risc_int_ctrl: directed vector table, corner sequences, randomized run vs. model.
module tb_risc_int_ctrl;

    logic        boardclk = 1'b0;
    logic        rst      = 1'b1;
    logic [3:0]  int_src  = '0;
    logic        en_we    = 1'b0;
    logic [3:0]  en_wdata = '0;
    logic [3:0]  en;
    logic [3:0]  pending;
    logic        irq_req;
    logic        irq_ack  = 1'b0;
    logic [1:0]  irq_id;
    logic [31:0] irq_vec;
    logic        iret     = 1'b0;
    logic        in_service;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: pending edges, mask, and which handshake phase the core is in.
    bit [3:0] m_pend;
    bit [3:0] m_en;
    bit [3:0] m_prev;
    bit       m_waiting_ack;
    bit       m_in_handler;
    int       m_id;
    bit [31:0] m_vec;

    typedef struct {
        logic        rst;
        logic [3:0]  src;
        logic        we;
        logic [3:0]  wd;
        logic        ack;
        logic        iret;
        logic        e_req;
        logic        e_serv;
        logic [1:0]  e_id;
        logic [31:0] e_vec;
        logic [3:0]  e_pend;
        logic [3:0]  e_en;
        logic        chk_id;
    } vec_t;

    vec_t tbl[$];

    risc_int_ctrl #(
        .NSRC       (4),
        .AW         (32),
        .VEC_BASE   (32'h0000_0040),
        .VEC_STRIDE (8)
    ) dut (
        .boardclk   (boardclk),
        .rst        (rst),
        .int_src    (int_src),
        .en_we      (en_we),
        .en_wdata   (en_wdata),
        .en         (en),
        .pending    (pending),
        .irq_req    (irq_req),
        .irq_ack    (irq_ack),
        .irq_id     (irq_id),
        .irq_vec    (irq_vec),
        .iret       (iret),
        .in_service (in_service)
    );

    always #5 boardclk = ~boardclk;

    task automatic model_step(input bit r, input bit [3:0] s, input bit we, input bit [3:0] wd,
                              input bit a, input bit ir);
        bit [3:0] rise;
        bit [3:0] avail;
        if (r) begin
            m_pend = '0; m_en = '0; m_prev = '0;
            m_waiting_ack = 0; m_in_handler = 0; m_id = 0; m_vec = '0;
            return;
        end
        rise   = s & ~m_prev;
        m_prev = s;
        if (m_waiting_ack) begin
            if (a) begin
                m_pend[m_id]  = 1'b0;
                m_waiting_ack = 0;
                m_in_handler  = 1;
            end
        end else if (m_in_handler) begin
            if (ir) m_in_handler = 0;
        end else begin
            avail = m_pend & m_en;
            if (avail != 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (avail[i]) begin
                        m_id = i;
                        break;
                    end
                end
                m_vec         = 32'h40 + 32'(m_id) * 8;
                m_waiting_ack = 1;
            end
        end
        m_pend = m_pend | rise;
        if (we) m_en = wd;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] s, input logic we, input logic [3:0] wd,
                                 input logic a, input logic ir);
        @(negedge boardclk);
        rst      = r;
        int_src  = s;
        en_we    = we;
        en_wdata = wd;
        irq_ack  = a;
        iret     = ir;
        model_step(r, s, we, wd, a, ir);
        @(posedge boardclk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic e_req, input logic e_serv, input logic [1:0] e_id,
                            input logic [31:0] e_vec, input logic [3:0] e_pend, input logic [3:0] e_en,
                            input logic chk_id);
        checkOutput({tag, "_req"}, 32'(irq_req), 32'(e_req));
        checkOutput({tag, "_serv"}, 32'(in_service), 32'(e_serv));
        checkOutput({tag, "_pend"}, 32'(pending), 32'(e_pend));
        checkOutput({tag, "_en"}, 32'(en), 32'(e_en));
        if (chk_id) begin
            checkOutput({tag, "_id"}, 32'(irq_id), 32'(e_id));
            checkOutput({tag, "_vec"}, irq_vec, e_vec);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fields: rst src we wd ack iret | req serv id vec pend en chk_id
        tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h4, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h50, 4'h4, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h50, 4'h4, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h50, 4'h0, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h50, 4'h0, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'hA, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h48, 4'hA, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h48, 4'h8, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h8, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h58, 4'h8, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'h58, 4'h0, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'h58, 4'h0, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'hE, 1'b0});
        tbl.push_back('{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h1, 4'hE, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h1, 4'hE, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'h1, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h40, 4'h1, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h40, 4'h0, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00, 4'h0, 4'hF, 1'b0});

        $display("[TB] directed vector table, %0d rows", tbl.size());
        foreach (tbl[k]) begin
            applyStimulus(tbl[k].rst, tbl[k].src, tbl[k].we, tbl[k].wd, tbl[k].ack, tbl[k].iret);
            checkAll($sformatf("row%0d", k), tbl[k].e_req, tbl[k].e_serv, tbl[k].e_id, tbl[k].e_vec,
                     tbl[k].e_pend, tbl[k].e_en, tbl[k].chk_id);
        end

        // Higher-priority edge while a request is outstanding must not change the frozen id.
        $display("[TB] sequence: frozen id in REQ");
        applyStimulus(0, 4'h4, 0, 4'h0, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkAll("frz_a", 1, 0, 2'd2, 32'h50, 4'h4, 4'hF, 1);
        applyStimulus(0, 4'h1, 0, 4'h0, 0, 0);
        checkAll("frz_b", 1, 0, 2'd2, 32'h50, 4'h5, 4'hF, 1);
        applyStimulus(0, 4'h0, 0, 4'h0, 1, 0);
        checkAll("frz_c", 0, 1, 2'd2, 32'h50, 4'h1, 4'hF, 1);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 1);
        checkAll("frz_d", 0, 0, 2'd0, 32'h00, 4'h1, 4'hF, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkAll("frz_e", 1, 0, 2'd0, 32'h40, 4'h1, 4'hF, 1);
        applyStimulus(0, 4'h0, 0, 4'h0, 1, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 1);
        checkAll("frz_f", 0, 0, 2'd0, 32'h00, 4'h0, 4'hF, 0);

        // Ack and a fresh edge on the same source in one cycle: the edge wins.
        $display("[TB] sequence: ack collides with new edge");
        applyStimulus(0, 4'h8, 0, 4'h0, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkAll("col_a", 1, 0, 2'd3, 32'h58, 4'h8, 4'hF, 1);
        applyStimulus(0, 4'h8, 0, 4'h0, 1, 0);
        checkAll("col_b", 0, 1, 2'd3, 32'h58, 4'h8, 4'hF, 1);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 1);
        checkAll("col_c", 0, 0, 2'd0, 32'h00, 4'h8, 4'hF, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkAll("col_d", 1, 0, 2'd3, 32'h58, 4'h8, 4'hF, 1);
        applyStimulus(0, 4'h0, 0, 4'h0, 1, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 1);
        checkAll("col_e", 0, 0, 2'd0, 32'h00, 4'h0, 4'hF, 0);

        // Reset in the middle of a handler abandons it; stray strobes afterwards do nothing.
        $display("[TB] sequence: reset during service");
        applyStimulus(0, 4'h2, 0, 4'h0, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 1, 0);
        checkAll("rst_a", 0, 1, 2'd1, 32'h48, 4'h0, 4'hF, 1);
        applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
        checkAll("rst_b", 0, 0, 2'd0, 32'h00, 4'h0, 4'h0, 1);
        applyStimulus(0, 4'h0, 0, 4'h0, 1, 1);
        checkAll("rst_c", 0, 0, 2'd0, 32'h00, 4'h0, 4'h0, 1);

        $display("[TB] randomized run against reference model");
        applyStimulus(1, 4'h0, 0, 4'h0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic [3:0] s;
            logic       we;
            logic [3:0] wd;
            logic       a;
            logic       ir;
            r  = ($urandom_range(0, 199) == 0);
            s  = 4'($urandom & $urandom);
            we = ($urandom_range(0, 11) == 0);
            wd = 4'($urandom);
            a  = ($urandom_range(0, 2) == 0);
            ir = ($urandom_range(0, 3) == 0);
            applyStimulus(r, s, we, wd, a, ir);
            checkAll("rnd", m_waiting_ack, m_in_handler, 2'(m_id), m_vec, m_pend, m_en,
                     m_waiting_ack | m_in_handler);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
